// File: rtl/imem_fetch_server.sv
// Y-86 instruction-memory responder: byte-wide program store, serial fetch, decoded response.
// Optional FETCH_COUNT_EN adds a wrapping 16-bit count of acknowledged fetches.
module imem_fetch_server #(
   parameter int unsigned MEM_BYTES = 2048,
   parameter int unsigned ADDR_W    = 11
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_i,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              ld_en_i,
   input  logic [ADDR_W-1:0] ld_addr_i,
   input  logic [7:0]        ld_data_i,
   output logic              busy_o,
   output logic              ack_o,
   output logic [3:0]        icode_o,
   output logic [3:0]        ifun_o,
   output logic [3:0]        ra_o,
   output logic [3:0]        rb_o,
   output logic [63:0]       valc_o,
   output logic [ADDR_W-1:0] valp_o,
   output logic              instr_valid_o,
   output logic              imem_error_o
`ifdef FETCH_COUNT_EN
   ,
   output logic [15:0]       fetch_count_o
`endif
);

   typedef enum logic [1:0] {StIdle, StRead, StResp} state_e;

   localparam logic [ADDR_W:0] MemEnd = (ADDR_W+1)'(MEM_BYTES);

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [7:0]        mem_q [MEM_BYTES];
   logic [7:0]        buf_q [10];
   logic [7:0]        bytes_c [10];
   logic [ADDR_W:0]   rd_addr, end_c;
   logic [7:0]        rd_byte;
   logic [3:0]        icode_c, len_c, ra_c, rb_c;
   logic              valid_c, oob_c, done_c;
   logic [63:0]       valc_c;
   logic [ADDR_W-1:0] valp_c;

   always_ff @(posedge clk_i) begin
      if (ld_en_i && ({1'b0, ld_addr_i} < MemEnd)) begin
         mem_q[ld_addr_i] <= ld_data_i;
      end
   end

   // Combinational read sees the pre-edge byte, so a clashing load is read-before-write.
   assign rd_addr = {1'b0, pc_q} + {{(ADDR_W-3){1'b0}}, cnt_q};
   assign rd_byte = (rd_addr < MemEnd) ? mem_q[rd_addr[ADDR_W-1:0]] : 8'h00;

   always_comb begin
      for (int i = 0; i < 10; i++) begin
         bytes_c[i] = (state_q == StRead && cnt_q == 4'(i)) ? rd_byte : buf_q[i];
      end
   end

   assign icode_c = bytes_c[0][7:4];

   always_comb begin
      len_c   = 4'd1;
      valid_c = 1'b1;
      unique case (icode_c)
         4'h0, 4'h1, 4'h9:       len_c = 4'd1;
         4'h2, 4'h6, 4'hA, 4'hB: len_c = 4'd2;
         4'h3, 4'h4, 4'h5:       len_c = 4'd10;
         4'h7, 4'h8:             len_c = 4'd9;
         default:                valid_c = 1'b0;
      endcase
   end

   assign end_c = {1'b0, pc_q} + {{(ADDR_W-3){1'b0}}, len_c};
   assign oob_c = end_c > MemEnd;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pc_d    = pc_q;
      done_c  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req_i) begin
               pc_d    = pc_i;
               cnt_d   = 4'd0;
               state_d = StRead;
            end
         end
         StRead: begin
            cnt_d = cnt_q + 4'd1;
            if ((cnt_q == 4'd0 && oob_c) || cnt_q == len_c - 4'd1) begin
               done_c  = 1'b1;
               state_d = StResp;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      ra_c   = 4'hF;
      rb_c   = 4'hF;
      valc_c = 64'h0;
      valp_c = end_c[ADDR_W-1:0];
      if (oob_c) begin
         valp_c = pc_q;
      end else begin
         if (len_c == 4'd2 || len_c == 4'd10) begin
            ra_c = bytes_c[1][7:4];
            rb_c = bytes_c[1][3:0];
         end
         for (int k = 0; k < 8; k++) begin
            if (len_c == 4'd10) valc_c[8*k +: 8] = bytes_c[k+2];
            if (len_c == 4'd9)  valc_c[8*k +: 8] = bytes_c[k+1];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (state_q == StRead) begin
         buf_q[cnt_q] <= rd_byte;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= StIdle;
         cnt_q         <= 4'd0;
         pc_q          <= '0;
         icode_o       <= 4'h0;
         ifun_o        <= 4'h0;
         ra_o          <= 4'hF;
         rb_o          <= 4'hF;
         valc_o        <= 64'h0;
         valp_o        <= '0;
         instr_valid_o <= 1'b0;
         imem_error_o  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pc_q    <= pc_d;
         if (done_c) begin
            icode_o       <= icode_c;
            ifun_o        <= bytes_c[0][3:0];
            ra_o          <= ra_c;
            rb_o          <= rb_c;
            valc_o        <= valc_c;
            valp_o        <= valp_c;
            instr_valid_o <= valid_c;
            imem_error_o  <= oob_c;
         end
      end
   end

   assign busy_o = (state_q != StIdle);
   assign ack_o  = (state_q == StResp);

`ifdef FETCH_COUNT_EN
   logic [15:0] fetch_count_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fetch_count_q <= 16'h0;
      end else if (state_q == StResp) begin
         fetch_count_q <= fetch_count_q + 16'h1;
      end
   end

   assign fetch_count_o = fetch_count_q;
`else
`endif

endmodule

// File: tb/tb_imem_fetch_server.sv
// Self-checking bench for imem_fetch_server: directed cases plus randomized fetches
// against a byte-array reference model of the program store.
module tb_imem_fetch_server;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic [10:0] pc = '0;
   logic        ld_en = 1'b0;
   logic [10:0] ld_addr = '0;
   logic [7:0]  ld_data = '0;
   logic        busy, ack, instr_valid, imem_error;
   logic [3:0]  icode, ifun, ra, rb;
   logic [63:0] valc;
   logic [10:0] valp;
`ifdef FETCH_COUNT_EN
   logic [15:0] fetch_count;
`endif

   int checks = 0;
   int failures = 0;
   int fc = 0;
   logic [7:0] mdl [2048];

   imem_fetch_server #(.MEM_BYTES(2048), .ADDR_W(11)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .req_i         (req),
      .pc_i          (pc),
      .ld_en_i       (ld_en),
      .ld_addr_i     (ld_addr),
      .ld_data_i     (ld_data),
      .busy_o        (busy),
      .ack_o         (ack),
      .icode_o       (icode),
      .ifun_o        (ifun),
      .ra_o          (ra),
      .rb_o          (rb),
      .valc_o        (valc),
      .valp_o        (valp),
      .instr_valid_o (instr_valid),
      .imem_error_o  (imem_error)
`ifdef FETCH_COUNT_EN
      ,
      .fetch_count_o (fetch_count)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load_byte(input int addr, input logic [7:0] data);
      ld_en   = 1'b1;
      ld_addr = 11'(addr);
      ld_data = data;
      @(posedge clk);
      #1;
      ld_en = 1'b0;
      mdl[addr] = data;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".busy"}, 64'(busy), 64'd0);
      check({tag, ".ack"}, 64'(ack), 64'd0);
      check({tag, ".icode"}, 64'(icode), 64'd0);
      check({tag, ".rarb"}, 64'({ra, rb}), 64'hFF);
      check({tag, ".valc"}, valc, 64'd0);
      check({tag, ".valp_flags"}, 64'({valp, instr_valid, imem_error}), 64'd0);
   endtask

   // Fetch from p; clash = write 0x00 to p on the edge that captures byte 0.
   task automatic do_fetch(input logic [10:0] p, input bit clash, input string tag);
      logic [7:0]  b [10];
      int          len, n, exp_lat;
      bit          vld, err;
      logic [3:0]  er, eb;
      logic [63:0] vc;
      logic [10:0] vp;
      for (int i = 0; i < 10; i++) begin
         b[i] = (int'(p) + i < 2048) ? mdl[int'(p) + i] : 8'h00;
      end
      vld = 1'b1;
      case (b[0][7:4])
         4'h0, 4'h1, 4'h9:       len = 1;
         4'h2, 4'h6, 4'hA, 4'hB: len = 2;
         4'h3, 4'h4, 4'h5:       len = 10;
         4'h7, 4'h8:             len = 9;
         default: begin len = 1; vld = 1'b0; end
      endcase
      err = (int'(p) + len > 2048);
      er = 4'hF; eb = 4'hF; vc = 64'h0;
      if (!err) begin
         if (len == 2 || len == 10) begin er = b[1][7:4]; eb = b[1][3:0]; end
         for (int k = 0; k < 8; k++) begin
            if (len == 10) vc[8*k +: 8] = b[k+2];
            if (len == 9)  vc[8*k +: 8] = b[k+1];
         end
      end
      vp = err ? p : 11'(int'(p) + len);
      exp_lat = err ? 2 : len + 1;

      req = 1'b1;
      pc  = p;
      @(posedge clk);
      #1;
      req = 1'b0;
      if (clash) begin
         ld_en = 1'b1; ld_addr = p; ld_data = 8'h00;
      end
      n = 1;
      while (!ack && n < 30) begin
         @(posedge clk);
         #1;
         ld_en = 1'b0;
         n++;
      end
      if (clash) mdl[int'(p)] = 8'h00;
      fc++;
      check({tag, ".latency"}, 64'(n), 64'(exp_lat));
      check({tag, ".icode_ifun"}, 64'({icode, ifun}), 64'(b[0]));
      check({tag, ".rarb"}, 64'({ra, rb}), 64'({er, eb}));
      check({tag, ".valc"}, valc, vc);
      check({tag, ".valp"}, 64'(valp), 64'(vp));
      check({tag, ".valid_err"}, 64'({instr_valid, imem_error}), 64'({vld, err}));
      @(posedge clk);
      #1;
      check({tag, ".ack_drop"}, 64'({ack, busy}), 64'd0);
      check({tag, ".hold"}, 64'({icode, valp}), 64'({b[0][7:4], vp}));
   endtask

   initial begin
      bit          seen;
      logic [10:0] rp;
      logic [3:0]  ic;

      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
`ifdef FETCH_COUNT_EN
      check("reset.count", 64'(fetch_count), 64'd0);
`endif
      rst = 1'b0;
      @(posedge clk);
      #1;

      load_byte(0, 8'h30);
      load_byte(1, 8'hF3);
      load_byte(2, 8'h0A);
      for (int i = 3; i < 10; i++) load_byte(i, 8'h00);
      do_fetch(11'd0, 1'b0, "irmov");

      load_byte(8'h40, 8'h70);
      load_byte(8'h41, 8'h20);
      for (int i = 8'h42; i < 8'h49; i++) load_byte(i, 8'h00);
      do_fetch(11'h40, 1'b0, "jmp");

      load_byte(5, 8'h00);
      do_fetch(11'd5, 1'b0, "halt");
      load_byte(7, 8'hD0);
      do_fetch(11'd7, 1'b0, "illegal");
      load_byte(2045, 8'h30);
      do_fetch(11'd2045, 1'b0, "oob");

      load_byte(100, 8'h10);
      do_fetch(11'd100, 1'b1, "rbw_old");
      do_fetch(11'd100, 1'b0, "rbw_new");

      // Abort an irmov fetch mid-read.
      req = 1'b1;
      pc  = 11'd0;
      @(posedge clk);
      #1;
      req = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_reset_outputs("abort");
      @(posedge clk);
      #1;
      rst = 1'b0;
      fc = 0;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (ack || busy) seen = 1'b1;
      end
      check("abort.no_ack", 64'(seen), 64'd0);
      do_fetch(11'd0, 1'b0, "refetch");
`ifdef FETCH_COUNT_EN
      check("refetch.count", 64'(fetch_count), 64'(fc));
`endif

      for (int it = 0; it < 40; it++) begin
         ic = 4'($urandom_range(0, 15));
         rp = (it % 4 == 0) ? 11'(2038 + $urandom_range(0, 9)) : 11'($urandom_range(0, 2047));
         load_byte(int'(rp), {ic, 4'($urandom_range(0, 15))});
         for (int i = 1; i < 10; i++) begin
            if (int'(rp) + i < 2048) load_byte(int'(rp) + i, 8'($urandom_range(0, 255)));
         end
         do_fetch(rp, 1'b0, "rand");
      end
`ifdef FETCH_COUNT_EN
      check("final.count", 64'(fetch_count), 64'(fc));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
